// File: rtl/led_panel_pkg.sv
// led_panel_pkg: shared constants and types for the LED panel capture block.
package led_panel_pkg;

  localparam int RGB_W = 3;
  localparam int PX_W  = 2 * RGB_W;
  localparam int ERR_W = 3;

  // Emitter states
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  // Bit positions inside o_err
  localparam int ERR_LENGTH    = 0;
  localparam int ERR_UNBLANKED = 1;
  localparam int ERR_OVERFLOW  = 2;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    rgb_t rgb_1;
    rgb_t rgb_0;
  } px_t;

endpackage

// File: rtl/led_panel_sync.sv
// led_panel_sync: N-stage synchroniser for a bundle of panel signals. The low
// EDGE_W bits also get a rising-edge strobe; the remaining bits are a plain
// delay that stays cycle-aligned with the strobed bits.
module led_panel_sync #(
  parameter int W      = 4,
  parameter int EDGE_W = 1,
  parameter int STAGES = 2
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [W-1:0]      d,
  output logic [W-1:EDGE_W] q_data,
  output logic [EDGE_W-1:0] rise
);

  logic [W-1:0]      stage_q [STAGES];
  logic [EDGE_W-1:0] prev_q;

  // Shift the whole bundle through identical flop chains, remember last edge bits
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1][EDGE_W-1:0];
    end
  end

  assign q_data = stage_q[STAGES-1][W-1:EDGE_W];
  assign rise   = stage_q[STAGES-1][EDGE_W-1:0] & ~prev_q;

endmodule

// File: rtl/led_panel_capture.sv
// led_panel_capture: virtual LED panel. Snoops the panel PMOD lines, rebuilds
// each latched row and replays it as a valid/ready pixel stream, flagging
// length, unblanked-latch and overflow errors.
// Optional: define LED_PANEL_CAPTURE_STATS_EN to add saturating o_rows_ok and
// o_err_count counters.
module led_panel_capture
  import led_panel_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ROW_BITS    = 3,
  parameter int ROW_OFFSET  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
`ifdef LED_PANEL_CAPTURE_STATS_EN
  output logic [15:0]              o_rows_ok,
  output logic [15:0]              o_err_count,
`endif
  input  logic                     i_lp_clock,
  input  logic                     i_lp_latch,
  input  logic                     i_lp_blank,
  input  logic [RGB_W-1:0]         i_lp_rgb_0,
  input  logic [RGB_W-1:0]         i_lp_rgb_1,
  input  logic [ROW_BITS-1:0]      i_lp_address,
  output logic                     o_px_valid,
  input  logic                     i_px_ready,
  output logic [ROW_BITS-1:0]      o_px_row,
  output logic [$clog2(WIDTH)-1:0] o_px_col,
  output logic [RGB_W-1:0]         o_px_rgb_0,
  output logic [RGB_W-1:0]         o_px_rgb_1,
  output logic                     o_frame_done,
  output logic [ERR_W-1:0]         o_err
);

  localparam int COL_W  = $clog2(WIDTH);
  localparam int CNT_W  = $clog2(WIDTH + 2);
  localparam int DATA_W = ROW_BITS + 1 + PX_W;
  localparam int BUS_W  = DATA_W + 2;

  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(WIDTH + 1);
  localparam logic [COL_W-1:0]    COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;
  localparam logic [ROW_BITS-1:0] ROW_ADD  = ROW_BITS'(ROW_OFFSET);

  // ---- synchronised panel lines: bit 0 = clock, bit 1 = latch ----
  logic [DATA_W-1:0]   data_s;
  logic [1:0]          rise_s;
  logic                clk_rise;
  logic                latch_rise;
  logic [ROW_BITS-1:0] addr_s;
  logic                blank_s;
  px_t                 px_in;

  led_panel_sync #(
    .W      (BUS_W),
    .EDGE_W (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .d         ({i_lp_address, i_lp_blank, i_lp_rgb_1, i_lp_rgb_0, i_lp_latch, i_lp_clock}),
    .q_data    (data_s),
    .rise      (rise_s)
  );

  assign clk_rise   = rise_s[0];
  assign latch_rise = rise_s[1];
  assign addr_s     = data_s[DATA_W-1 -: ROW_BITS];
  assign blank_s    = data_s[PX_W];
  assign px_in      = data_s[PX_W-1:0];

  // ---- capture state ----
  px_t                 shift_q    [WIDTH];
  px_t                 shift_next [WIDTH];
  px_t                 hold_q     [WIDTH];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_next;
  logic [ERR_W-1:0]    err_next;
  logic                accept;
  logic [0:0]          state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_BITS-1:0] row_q;

  // Apply a panel clock edge first so a same-cycle latch sees the updated count
  always_comb begin
    shift_next = shift_q;
    cnt_next   = cnt_q;
    if (clk_rise) begin
      shift_next[0] = px_in;
      for (int i = 1; i < WIDTH; i++) shift_next[i] = shift_q[i-1];
      if (cnt_q != CNT_MAX) cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // Latch decision: a wrong length wins over a busy emitter; blank is judged separately
  always_comb begin
    err_next = '0;
    accept   = 1'b0;
    if (latch_rise) begin
      if (cnt_next != CNT_FULL)  err_next[ERR_LENGTH]   = 1'b1;
      else if (state_q != S_IDLE) err_next[ERR_OVERFLOW] = 1'b1;
      else                        accept                 = 1'b1;
      if (!blank_s) err_next[ERR_UNBLANKED] = 1'b1;
    end
  end

  // Shift register, column count and hold buffer
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        shift_q[i] <= '0;
        hold_q[i]  <= '0;
      end
      cnt_q <= '0;
      o_err <= '0;
    end else begin
      shift_q <= shift_next;
      cnt_q   <= latch_rise ? '0 : cnt_next;
      o_err   <= err_next;
      if (accept) hold_q <= shift_next;
    end
  end

  // Emitter FSM: replay the hold buffer column by column under backpressure
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q <= S_DRAIN;
            col_q   <= '0;
            row_q   <= addr_s + ROW_ADD;
          end
        end
        default: begin
          if (i_px_ready) begin
            if (col_q == COL_LAST) state_q <= S_IDLE;
            else                   col_q   <= col_q + COL_W'(1);
          end
        end
      endcase
    end
  end

  assign o_px_valid   = (state_q == S_DRAIN);
  assign o_px_col     = col_q;
  assign o_px_row     = row_q;
  assign o_px_rgb_0   = hold_q[col_q].rgb_0;
  assign o_px_rgb_1   = hold_q[col_q].rgb_1;
  assign o_frame_done = o_px_valid && i_px_ready && (col_q == COL_LAST) && (row_q == ROW_LAST);

`ifdef LED_PANEL_CAPTURE_STATS_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic [1:0] err_num;
  assign err_num = {1'b0, err_next[ERR_LENGTH]} + {1'b0, err_next[ERR_UNBLANKED]}
                 + {1'b0, err_next[ERR_OVERFLOW]};

  // Saturating health counters
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_rows_ok   <= '0;
      o_err_count <= '0;
    end else begin
      o_rows_ok   <= sat_add16(o_rows_ok, {1'b0, accept});
      o_err_count <= sat_add16(o_err_count, err_num);
    end
  end
`endif

endmodule

// File: tb/tb_led_panel_capture.sv
// tb_led_panel_capture: directed bench for led_panel_capture (default build).
module tb_led_panel_capture;

  localparam int WIDTH    = 32;
  localparam int ROW_BITS = 3;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                lp_clock, lp_latch, lp_blank;
  logic [2:0]          lp_rgb_0, lp_rgb_1;
  logic [ROW_BITS-1:0] lp_address;
  logic                px_valid, px_ready;
  logic [ROW_BITS-1:0] px_row;
  logic [4:0]          px_col;
  logic [2:0]          px_rgb_0, px_rgb_1;
  logic                frame_done;
  logic [2:0]          err;
`ifdef LED_PANEL_CAPTURE_STATS_EN
  logic [15:0]         rows_ok, err_count;
`endif

  always #5 clk = ~clk;

  led_panel_capture #(
    .WIDTH(WIDTH), .ROW_BITS(ROW_BITS), .ROW_OFFSET(1), .SYNC_STAGES(2)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (reset_n),
`ifdef LED_PANEL_CAPTURE_STATS_EN
    .o_rows_ok    (rows_ok),
    .o_err_count  (err_count),
`endif
    .i_lp_clock   (lp_clock),
    .i_lp_latch   (lp_latch),
    .i_lp_blank   (lp_blank),
    .i_lp_rgb_0   (lp_rgb_0),
    .i_lp_rgb_1   (lp_rgb_1),
    .i_lp_address (lp_address),
    .o_px_valid   (px_valid),
    .i_px_ready   (px_ready),
    .o_px_row     (px_row),
    .o_px_col     (px_col),
    .o_px_rgb_0   (px_rgb_0),
    .o_px_rgb_1   (px_rgb_1),
    .o_frame_done (frame_done),
    .o_err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Event counters, updated once per cycle mid-way between clock edges
  int v_cnt = 0, fd_cnt = 0, e_len = 0, e_unb = 0, e_ovf = 0;
  int fd_row = -1, fd_col = -1;
  int b_v, b_len, b_unb, b_ovf;

  always @(negedge clk) begin
    #1;
    if (px_valid === 1'b1) v_cnt++;
    if (err[0] === 1'b1) e_len++;
    if (err[1] === 1'b1) e_unb++;
    if (err[2] === 1'b1) e_ovf++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_row = int'(px_row);
      fd_col = int'(px_col);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pat0(input int c, input int seed);
    return 3'(c + seed);
  endfunction

  function automatic logic [2:0] pat1(input int c, input int seed);
    return 3'((c >> 2) ^ seed);
  endfunction

  // First shifted column ends up as col WIDTH-1, so send columns high to low
  task automatic shift_row(input int seed, input int ncols);
    for (int k = ncols - 1; k >= 0; k--) begin
      lp_rgb_0 = pat0(k, seed);
      lp_rgb_1 = pat1(k, seed);
      lp_clock = 1'b1;
      tick();
      lp_clock = 1'b0;
      tick();
    end
  endtask

  task automatic send_latch(input int addr, input logic blank);
    lp_address = 3'(addr);
    lp_blank   = blank;
    lp_latch   = 1'b1;
    tick();
    lp_latch   = 1'b0;
    tick();
    lp_blank   = 1'b1;
  endtask

  task automatic snap();
    b_v = v_cnt; b_len = e_len; b_unb = e_unb; b_ovf = e_ovf;
  endtask

  task automatic chk_err(input string tag, input int l, input int u, input int o);
    chk({tag, " err_length"},    32'(e_len - b_len), 32'(l));
    chk({tag, " err_unblanked"}, 32'(e_unb - b_unb), 32'(u));
    chk({tag, " err_overflow"},  32'(e_ovf - b_ovf), 32'(o));
  endtask

  // Consume a row with ready high, optionally stalling 10 cycles at stall_col
  // and optionally stopping (unaccepted) at stop_col
  task automatic drain(input int row, input int seed, input int stall_col, input int stop_col);
    int waited;
    waited   = 0;
    px_ready = 1'b1;
    while (px_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk($sformatf("drain_start r%0d", row), 32'(px_valid), 32'd1);
    for (int c = 0; c < WIDTH; c++) begin
      chk($sformatf("px_valid r%0d c%0d", row, c), 32'(px_valid), 32'd1);
      chk($sformatf("px_row r%0d c%0d", row, c), 32'(px_row), 32'(row));
      chk($sformatf("px_col r%0d c%0d", row, c), 32'(px_col), 32'(c));
      chk($sformatf("px_rgb_0 r%0d c%0d", row, c), 32'(px_rgb_0), 32'(pat0(c, seed)));
      chk($sformatf("px_rgb_1 r%0d c%0d", row, c), 32'(px_rgb_1), 32'(pat1(c, seed)));
      if (c == stall_col) begin
        px_ready = 1'b0;
        tick(10);
        chk($sformatf("stall_valid c%0d", c), 32'(px_valid), 32'd1);
        chk($sformatf("stall_col c%0d", c), 32'(px_col), 32'(c));
        chk($sformatf("stall_rgb_0 c%0d", c), 32'(px_rgb_0), 32'(pat0(c, seed)));
        chk($sformatf("stall_rgb_1 c%0d", c), 32'(px_rgb_1), 32'(pat1(c, seed)));
        px_ready = 1'b1;
      end
      if (c == stop_col) return;
      tick();
    end
  endtask

  initial begin
    int fd_base;
    reset_n    = 1'b0;
    lp_clock   = 1'b0;
    lp_latch   = 1'b0;
    lp_blank   = 1'b1;
    lp_rgb_0   = '0;
    lp_rgb_1   = '0;
    lp_address = '0;
    px_ready   = 1'b1;
    tick(3);
    chk("reset px_valid",   32'(px_valid),   32'd0);
    chk("reset err",        32'(err),        32'd0);
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset px_col",     32'(px_col),     32'd0);
    chk("reset px_row",     32'(px_row),     32'd0);
    chk("reset px_rgb_0",   32'(px_rgb_0),   32'd0);
    chk("reset px_rgb_1",   32'(px_rgb_1),   32'd0);
    reset_n = 1'b1;
    tick(2);

    // 1: basic row, addr 2 -> row 3, exact latch-to-valid latency
    snap();
    shift_row(0, WIDTH);
    send_latch(2, 1'b1);
    chk("t1 valid before latency", 32'(px_valid), 32'd0);
    tick();
    chk("t1 valid at latency", 32'(px_valid), 32'd1);
    drain(3, 0, -1, -1);
    chk("t1 valid low after row", 32'(px_valid), 32'd0);
    chk_err("t1", 0, 0, 0);

    // 2: 10-cycle stall at column 10
    snap();
    shift_row(1, WIDTH);
    send_latch(4, 1'b1);
    drain(5, 1, 10, -1);
    chk("t2 valid low after row", 32'(px_valid), 32'd0);
    chk_err("t2", 0, 0, 0);

    // 3: short row is discarded, next row is fine
    snap();
    shift_row(2, WIDTH - 1);
    send_latch(6, 1'b1);
    tick(4);
    chk_err("t3 short", 1, 0, 0);
    chk("t3 no valid for short row", 32'(v_cnt - b_v), 32'd0);
    shift_row(3, WIDTH);
    send_latch(0, 1'b1);
    drain(1, 3, -1, -1);
    chk_err("t3 after", 1, 0, 0);

    // 4: second row latched while first is stalled -> overflow, first row intact
    snap();
    px_ready = 1'b0;
    shift_row(4, WIDTH);
    send_latch(1, 1'b1);
    tick(2);
    chk("t4 valid stalled", 32'(px_valid), 32'd1);
    chk("t4 col stalled",   32'(px_col),   32'd0);
    shift_row(5, WIDTH);
    send_latch(3, 1'b1);
    tick(3);
    chk_err("t4", 0, 0, 1);
    chk("t4 col still 0", 32'(px_col), 32'd0);
    drain(2, 4, -1, -1);
    tick(8);
    chk("t4 second row discarded", 32'(px_valid), 32'd0);

    // 5: full frame, frame_done only at last pixel of row 7
    fd_base = fd_cnt;
    for (int a = 0; a < 8; a++) begin
      shift_row(8 + a, WIDTH);
      send_latch(a, 1'b1);
      drain((a + 1) % 8, 8 + a, -1, -1);
      chk($sformatf("t5 frame_done count after addr %0d", a), 32'(fd_cnt - fd_base),
          (a >= 6) ? 32'd1 : 32'd0);
    end
    chk("t5 frame_done row", 32'(fd_row), 32'd7);
    chk("t5 frame_done col", 32'(fd_col), 32'd31);

    // 6: unblanked latch still emits; reset mid-drain clears everything
    snap();
    shift_row(6, WIDTH);
    send_latch(2, 1'b0);
    drain(3, 6, -1, -1);
    chk_err("t6", 0, 1, 0);
    shift_row(7, WIDTH);
    send_latch(5, 1'b1);
    drain(6, 7, -1, 12);
    reset_n = 1'b0;
    tick();
    chk("t6 reset px_valid",   32'(px_valid),   32'd0);
    chk("t6 reset err",        32'(err),        32'd0);
    chk("t6 reset px_col",     32'(px_col),     32'd0);
    chk("t6 reset px_row",     32'(px_row),     32'd0);
    chk("t6 reset px_rgb_0",   32'(px_rgb_0),   32'd0);
    chk("t6 reset frame_done", 32'(frame_done), 32'd0);
    reset_n = 1'b1;
    tick(3);
    chk("t6 idle after reset", 32'(px_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
